// File: rtl/core_bus_arbiter_if.sv
// Memory-side valid/ready bus between core_bus_arbiter and the single memory port.
//   master : arbiter side, drives valid/we/addr/wdata/wmask, receives ready/rdata
//   slave  : memory side, receives the request, returns a one-cycle ready with rdata
interface core_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output valid, we, addr, wdata, wmask,
        input  ready, rdata
    );

    modport slave (
        input  valid, we, addr, wdata, wmask,
        output ready, rdata
    );
endinterface

// File: rtl/core_bus_arbiter.sv
// Two-port to one-bus arbiter between Core and memory. Serialises the fetch port
// (if_request/if_addr) and the data port (mem_re/mem_we/...) onto a single
// valid/ready bus, data accesses taking priority over fetches.
//   clk, rstn        : clock, synchronous active-low reset
//   if_*             : fetch request in, if_stall/if_rdata back to Core
//   mem_*            : data request in, mem_stall/mem_rdata back to Core
//   bus (master)     : memory bus, valid/we/addr/wdata/wmask out, ready/rdata in
//   bus_err          : sticky bus timeout flag
// Optional feature: define ARB_TIMEOUT_EN to enable a TIMEOUT_CYCLES watchdog
// that aborts a hung bus transaction; otherwise bus_err is tied 0.
module core_bus_arbiter #(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                if_request,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_stall,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                mem_re,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wmask,
    output logic                mem_stall,
    output logic [DATA_W-1:0]   mem_rdata,
    core_bus_arbiter_if.master  bus,
    output logic                bus_err
);
    localparam int unsigned MASK_W = DATA_W / 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("core_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUS  = 2'd1,
        ST_MEM_BUS = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t            state_q, state_nxt;

    // Pending latches and the request fields captured with them
    logic              if_pend_q, if_pend_nxt;
    logic [ADDR_W-1:0] if_addr_q, if_addr_nxt;
    logic              mem_pend_q, mem_pend_nxt;
    logic              mem_we_q, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
    logic [MASK_W-1:0] mem_wmask_q, mem_wmask_nxt;

    // Registered outputs
    logic              bus_valid_q, bus_valid_nxt;
    logic              bus_we_q, bus_we_nxt;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_nxt;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_nxt;
    logic [MASK_W-1:0] bus_wmask_q, bus_wmask_nxt;
    logic              if_stall_q, if_stall_nxt;
    logic              mem_stall_q, mem_stall_nxt;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_nxt;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_nxt;

    logic              mem_req_c;
    logic              timeout_c;

    assign mem_req_c = mem_re | mem_we;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             bus_err_q, bus_err_nxt;

    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts cycles spent in a bus state, restarts on every state entry
    always_comb begin
        cnt_nxt     = '0;
        bus_err_nxt = bus_err_q;
        if ((state_q == ST_IF_BUS) || (state_q == ST_MEM_BUS)) begin
            if (state_nxt == state_q) begin
                cnt_nxt = cnt_q + CNT_W'(1);
            end
            if (!bus.ready && timeout_c) begin
                bus_err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_nxt;
            bus_err_q <= bus_err_nxt;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout_c = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // Next-state, latch capture and output computation
    always_comb begin
        state_nxt     = state_q;
        if_pend_nxt   = if_pend_q;
        if_addr_nxt   = if_addr_q;
        mem_pend_nxt  = mem_pend_q;
        mem_we_nxt    = mem_we_q;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;
        mem_wmask_nxt = mem_wmask_q;
        bus_we_nxt    = bus_we_q;
        bus_addr_nxt  = bus_addr_q;
        bus_wdata_nxt = bus_wdata_q;
        bus_wmask_nxt = bus_wmask_q;
        if_rdata_nxt  = if_rdata_q;
        mem_rdata_nxt = mem_rdata_q;

        // A set latch covers both "pending" and "in flight", so repeats are dropped
        if (if_request && !if_pend_q) begin
            if_pend_nxt = 1'b1;
            if_addr_nxt = if_addr;
        end
        if (mem_req_c && !mem_pend_q) begin
            mem_pend_nxt  = 1'b1;
            mem_we_nxt    = mem_we;
            mem_addr_nxt  = mem_addr;
            mem_wdata_nxt = mem_wdata;
            mem_wmask_nxt = mem_wmask;
        end

        unique case (state_q)
            ST_IDLE: begin
                // Same-cycle requests are visible through the *_nxt latch values
                if (mem_pend_nxt) begin
                    state_nxt     = ST_MEM_BUS;
                    bus_we_nxt    = mem_we_nxt;
                    bus_addr_nxt  = mem_addr_nxt;
                    bus_wdata_nxt = mem_wdata_nxt;
                    bus_wmask_nxt = mem_wmask_nxt;
                end else if (if_pend_nxt) begin
                    state_nxt     = ST_IF_BUS;
                    bus_we_nxt    = 1'b0;
                    bus_addr_nxt  = if_addr_nxt;
                    bus_wdata_nxt = '0;
                    bus_wmask_nxt = '0;
                end
            end
            ST_IF_BUS: begin
                if (bus.ready) begin
                    if_rdata_nxt = bus.rdata;
                    if_pend_nxt  = 1'b0;
                    state_nxt    = ST_RESP;
                end else if (timeout_c) begin
                    if_rdata_nxt = '0;
                    if_pend_nxt  = 1'b0;
                    state_nxt    = ST_RESP;
                end
            end
            ST_MEM_BUS: begin
                if (bus.ready) begin
                    if (!mem_we_q) begin
                        mem_rdata_nxt = bus.rdata;
                    end
                    mem_pend_nxt = 1'b0;
                    state_nxt    = ST_RESP;
                end else if (timeout_c) begin
                    if (!mem_we_q) begin
                        mem_rdata_nxt = '0;
                    end
                    mem_pend_nxt = 1'b0;
                    state_nxt    = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        bus_valid_nxt = (state_nxt == ST_IF_BUS) || (state_nxt == ST_MEM_BUS);
        if_stall_nxt  = if_pend_nxt;
        mem_stall_nxt = mem_pend_nxt;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            if_pend_q   <= 1'b0;
            if_addr_q   <= '0;
            mem_pend_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
            if_stall_q  <= 1'b0;
            mem_stall_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_nxt;
            if_pend_q   <= if_pend_nxt;
            if_addr_q   <= if_addr_nxt;
            mem_pend_q  <= mem_pend_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            mem_wmask_q <= mem_wmask_nxt;
            bus_valid_q <= bus_valid_nxt;
            bus_we_q    <= bus_we_nxt;
            bus_addr_q  <= bus_addr_nxt;
            bus_wdata_q <= bus_wdata_nxt;
            bus_wmask_q <= bus_wmask_nxt;
            if_stall_q  <= if_stall_nxt;
            mem_stall_q <= mem_stall_nxt;
            if_rdata_q  <= if_rdata_nxt;
            mem_rdata_q <= mem_rdata_nxt;
        end
    end

    assign bus.valid = bus_valid_q;
    assign bus.we    = bus_we_q;
    assign bus.addr  = bus_addr_q;
    assign bus.wdata = bus_wdata_q;
    assign bus.wmask = bus_wmask_q;
    assign if_stall  = if_stall_q;
    assign mem_stall = mem_stall_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
endmodule
